// File: rtl/panda_data_mem.sv
// panda_data_mem: data-port responder for panda_core.
// Holds a word-organised RAM with byte-lane writes and an MMIO window with a
// 64-bit cycle counter, a TOHOST/halt register and a character-output FIFO
// that drains over a valid/ready stream. Reads are combinational because the
// core samples load data in the same cycle it drives the address.
module panda_data_mem #(
    parameter int unsigned RAM_DEPTH = 4096,           // 32-bit words, power of 2
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,  // window spans BASE..BASE+0xFF
    parameter int unsigned TX_DEPTH  = 8               // power of 2, 2..128
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        halt_o,
    output logic [31:0] tohost_o
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    // One extra bit so that count can hold TX_DEPTH itself.
    localparam int unsigned CNT_W  = TX_AW + 1;

    localparam logic [29:0]      MMIO_WBASE = MMIO_BASE[31:2];
    localparam logic [29:0]      RAM_WORDS  = 30'(RAM_DEPTH);
    localparam logic [CNT_W-1:0] TX_FULL    = CNT_W'(TX_DEPTH);

    // MMIO registers, indexed by word offset inside the window.
    typedef enum logic [5:0] {
        REG_CYCLE_LO = 6'h00,
        REG_CYCLE_HI = 6'h01,
        REG_TOHOST   = 6'h02,
        REG_TXDATA   = 6'h03,
        REG_TXSTAT   = 6'h04
    } mmio_reg_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]       w_word_addr;
    logic [29:0]       w_mmio_word;
    logic [5:0]        w_mmio_idx;
    logic              w_is_mmio;
    logic              w_is_ram;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_unused_addr_lsbs;

    // All accesses are word-aligned, so the byte offset bits are dropped.
    assign w_word_addr        = data_addr_i[31:2];
    assign w_unused_addr_lsbs = &{1'b0, data_addr_i[1:0]};

    // Subtracting the base keeps the window test correct for any base value.
    assign w_mmio_word = w_word_addr - MMIO_WBASE;
    assign w_is_mmio   = (w_mmio_word[29:6] == 24'h0);
    assign w_mmio_idx  = w_mmio_word[5:0];

    // MMIO takes priority over RAM if the two ever overlap.
    assign w_is_ram  = !w_is_mmio && (w_word_addr < RAM_WORDS);
    assign w_ram_idx = w_word_addr[RAM_AW-1:0];

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    logic       w_tohost_wr;
    logic       w_push_req;
    logic       w_ovf_clr;
    logic [3:0] w_ram_we;

    assign w_tohost_wr = w_is_mmio && (w_mmio_idx == REG_TOHOST) && (|data_we_i);
    assign w_push_req  = w_is_mmio && (w_mmio_idx == REG_TXDATA) && data_we_i[0];
    assign w_ovf_clr   = w_is_mmio && (w_mmio_idx == REG_TXSTAT) && data_we_i[0]
                         && data_wdata_i[2];
    assign w_ram_we    = w_is_ram ? data_we_i : 4'h0;

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [31:0] r_mem [RAM_DEPTH];

    // Byte-lane RAM write. Old data stays visible until the edge commits it.
    // NOTE: memory contents are deliberately left out of reset; this keeps the
    // array mappable to RAM macros and lets a write in a reset cycle complete.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (w_ram_we[b]) begin
                r_mem[w_ram_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [63:0] r_cycle;

    // Free-running 64-bit counter; wraps naturally at 2^64.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cycle <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // TOHOST / halt
    // ------------------------------------------------------------------
    logic [31:0] r_tohost;
    logic        r_halt;
    logic [31:0] w_tohost_merged;

    // Merge only the enabled byte lanes over the current register value.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_tohost_merged = r_tohost;
        for (int b = 0; b < 4; b++) begin
            if (data_we_i[b]) begin
                w_tohost_merged[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

    // TOHOST register and sticky halt flag, set when a write leaves bit 0 high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tohost <= 32'h0;
            r_halt   <= 1'b0;
        end else if (w_tohost_wr) begin
            r_tohost <= w_tohost_merged;
            if (w_tohost_merged[0]) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign tohost_o = r_tohost;
    assign halt_o   = r_halt;

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]       r_tx_buf [TX_DEPTH];
    logic [TX_AW-1:0] r_wr_ptr;
    logic [TX_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == TX_FULL);
    assign w_pop   = !w_empty && tx_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && !w_push;

    // Storage write; a stale entry is harmless because pointers gate validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tx_buf[r_wr_ptr] <= data_wdata_i[7:0];
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign tx_valid_o = !w_empty;
    assign tx_data_o  = r_tx_buf[r_rd_ptr];

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [31:0] w_txstat;

    assign w_txstat = {16'h0, 8'(r_count), 5'h0, r_overflow, w_full, w_empty};

    // Combinational read mux; reads never change state.
    always_comb begin
        data_rdata_o = 32'h0;
        if (w_is_mmio) begin
            case (w_mmio_idx)
                REG_CYCLE_LO: data_rdata_o = r_cycle[31:0];
                REG_CYCLE_HI: data_rdata_o = r_cycle[63:32];
                REG_TOHOST:   data_rdata_o = r_tohost;
                REG_TXSTAT:   data_rdata_o = w_txstat;
                default:      data_rdata_o = 32'h0;
            endcase
        end else if (w_is_ram) begin
            data_rdata_o = r_mem[w_ram_idx];
        end
    end

endmodule
